// File: rtl/not_vector_checker.sv
// Checks (stimulus, response) pairs from a NOT gate stage against ~stimulus and
// reports a pass/fail verdict, counters and the first failing vector per run.
module not_vector_checker #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_seen,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_a,
    output logic [WIDTH-1:0] first_fail_s,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             fail_seen_q, fail_seen_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [WIDTH-1:0] ff_a_q, ff_a_d;
    logic [WIDTH-1:0] ff_s_q, ff_s_d;

    logic accept;
    logic mismatch;
    logic last_vec;

    // Handshake: a vector is consumed on a rising edge where in_valid && in_ready.
    // in_ready is decoded from registered state only, so it never depends on in_valid.
    assign accept   = in_valid && (state_q == RUN);
    assign mismatch = (in_s != ~in_a);
    assign last_vec = (idx_q == (target_q - CNT_W'(1)));

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        idx_d       = idx_q;
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        fail_seen_d = fail_seen_q;
        ff_idx_d    = ff_idx_q;
        ff_a_d      = ff_a_q;
        ff_s_d      = ff_s_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d    = num_vec;
                    idx_d       = '0;
                    pass_cnt_d  = '0;
                    fail_cnt_d  = '0;
                    fail_seen_d = 1'b0;
                    ff_idx_d    = '0;
                    ff_a_d      = '0;
                    ff_s_d      = '0;
                    state_d     = (num_vec == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Data inputs are only looked at on accept, so X elsewhere is harmless.
                if (accept) begin
                    idx_d = idx_q + CNT_W'(1);
                    if (mismatch) begin
                        fail_cnt_d = fail_cnt_q + CNT_W'(1);
                        if (!fail_seen_q) begin
                            fail_seen_d = 1'b1;
                            ff_idx_d    = idx_q;
                            ff_a_d      = in_a;
                            ff_s_d      = in_s;
                        end
                    end else begin
                        pass_cnt_d = pass_cnt_q + CNT_W'(1);
                    end
                    if (last_vec) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            target_q    <= '0;
            idx_q       <= '0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            fail_seen_q <= 1'b0;
            ff_idx_q    <= '0;
            ff_a_q      <= '0;
            ff_s_q      <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            idx_q       <= idx_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            fail_seen_q <= fail_seen_d;
            ff_idx_q    <= ff_idx_d;
            ff_a_q      <= ff_a_d;
            ff_s_q      <= ff_s_d;
        end
    end

    assign in_ready       = (state_q == RUN);
    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = (state_q == DONE) && (fail_cnt_q == '0);
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign fail_seen      = fail_seen_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_a   = ff_a_q;
    assign first_fail_s   = ff_s_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_not_vector_checker.sv
// Directed bench for not_vector_checker: a 1-bit instance for the main flows and
// a 4-bit instance for stalls and multi-bit compares.
module tb_not_vector_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 1-bit instance
  logic       start1 = 1'b0;
  logic [7:0] num1 = '0;
  logic       v1 = 1'b0;
  logic       a1 = 1'b0, s1 = 1'b0;
  logic       rdy1, busy1, done1, pass1, fs1, ffa1, ffs1;
  logic [7:0] pc1, fc1, ffi1;
  logic [1:0] st1;

  // 4-bit instance
  logic       start4 = 1'b0;
  logic [7:0] num4 = '0;
  logic       v4 = 1'b0;
  logic [3:0] a4 = '0, s4 = '0;
  logic       rdy4, busy4, done4, pass4, fs4;
  logic [3:0] ffa4, ffs4;
  logic [7:0] pc4, fc4, ffi4;
  logic [1:0] st4;

  not_vector_checker #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .num_vec(num1),
    .in_valid(v1), .in_ready(rdy1), .in_a(a1), .in_s(s1),
    .busy(busy1), .done(done1), .pass(pass1), .pass_cnt(pc1), .fail_cnt(fc1),
    .fail_seen(fs1), .first_fail_idx(ffi1), .first_fail_a(ffa1),
    .first_fail_s(ffs1), .dbg_state(st1)
  );

  not_vector_checker #(.WIDTH(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .num_vec(num4),
    .in_valid(v4), .in_ready(rdy4), .in_a(a4), .in_s(s4),
    .busy(busy4), .done(done4), .pass(pass4), .pass_cnt(pc4), .fail_cnt(fc4),
    .fail_seen(fs4), .first_fail_idx(ffi4), .first_fail_a(ffa4),
    .first_fail_s(ffs4), .dbg_state(st4)
  );

  int n_checks = 0;
  int n_pass = 0;
  int acc4 = 0;

  always @(posedge clk) if (v4 && rdy4) acc4 <= acc4 + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_u1(input logic [7:0] n);
    start1 = 1'b1;
    num1 = n;
    tick();
    start1 = 1'b0;
  endtask

  task automatic vec_u1(input logic a, input logic s);
    v1 = 1'b1;
    a1 = a;
    s1 = s;
    tick();
    v1 = 1'b0;
    a1 = 1'bx;
    s1 = 1'bx;
  endtask

  task automatic cyc_u4(input logic v, input logic [3:0] a, input logic [3:0] s);
    v4 = v;
    a4 = a;
    s4 = s;
    tick();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", rdy1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_state", st1, 0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", rdy1, 0);

    // Two passing vectors
    start_u1(8'd2);
    check("t1_ready", rdy1, 1);
    check("t1_busy", busy1, 1);
    vec_u1(1'b0, 1'b1);
    check("t1_notdone", done1, 0);
    vec_u1(1'b1, 1'b0);
    check("t1_done", done1, 1);
    check("t1_pass", pass1, 1);
    check("t1_pc", pc1, 2);
    check("t1_fc", fc1, 0);
    check("t1_fs", fs1, 0);
    check("t1_ready_off", rdy1, 0);

    // Four vectors, two failing; first fail at index 1
    start_u1(8'd4);
    check("t2_done_drop", done1, 0);
    vec_u1(1'b0, 1'b1);
    vec_u1(1'b1, 1'b1);
    vec_u1(1'b0, 1'b0);
    vec_u1(1'b1, 1'b0);
    check("t2_done", done1, 1);
    check("t2_pass", pass1, 0);
    check("t2_pc", pc1, 2);
    check("t2_fc", fc1, 2);
    check("t2_ffi", ffi1, 1);
    check("t2_ffa", ffa1, 1);
    check("t2_ffs", ffs1, 1);

    // Zero-length run
    start_u1(8'd0);
    check("t4_done", done1, 1);
    check("t4_pass", pass1, 1);
    check("t4_pc", pc1, 0);
    check("t4_fc", fc1, 0);
    check("t4_ready", rdy1, 0);
    check("t4_fs", fs1, 0);

    // Start ignored during RUN, then restart from DONE
    start_u1(8'd3);
    vec_u1(1'b0, 1'b1);
    start_u1(8'd1);
    check("t5_ignored_busy", busy1, 1);
    check("t5_ignored_pc", pc1, 1);
    vec_u1(1'b1, 1'b0);
    check("t5_still_busy", busy1, 1);
    vec_u1(1'b0, 1'b0);
    check("t5_done", done1, 1);
    check("t5_pc", pc1, 2);
    check("t5_fc", fc1, 1);
    check("t5_ffi", ffi1, 2);
    start_u1(8'd1);
    check("t5_re_busy", busy1, 1);
    check("t5_re_pc", pc1, 0);
    check("t5_re_fc", fc1, 0);
    check("t5_re_fs", fs1, 0);
    vec_u1(1'b1, 1'b1);
    check("t5_re_done", done1, 1);
    check("t5_re_fc2", fc1, 1);
    check("t5_re_ffi", ffi1, 0);

    // 4-bit stalls: valid 1,0,0,1,1
    num4 = 8'd3;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc_u4(1'b1, 4'hA, 4'h5);
    cyc_u4(1'b0, 4'hx, 4'hx);
    cyc_u4(1'b0, 4'hx, 4'hx);
    check("t3_stall_busy", busy4, 1);
    cyc_u4(1'b1, 4'h3, 4'hC);
    cyc_u4(1'b1, 4'hF, 4'h1);
    check("t3_done", done4, 1);
    check("t3_ready_off", rdy4, 0);
    cyc_u4(1'b1, 4'h0, 4'h0);
    v4 = 1'b0;
    check("t3_accepts", acc4, 3);
    check("t3_pc", pc4, 2);
    check("t3_fc", fc4, 1);
    check("t3_ffi", ffi4, 2);
    check("t3_ffa", ffa4, 4'hF);
    check("t3_ffs", ffs4, 4'h1);
    check("t3_pass", pass4, 0);

    // Asynchronous reset mid-run
    start_u1(8'd3);
    vec_u1(1'b0, 1'b0);
    check("t6_fc_pre", fc1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_fc", fc1, 0);
    check("t6_busy", busy1, 0);
    check("t6_ready", rdy1, 0);
    check("t6_fs", fs1, 0);
    check("t6_state", st1, 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("t6_idle", st1, 0);
    check("t6_ready_after", rdy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
